// File: rtl/dev_gpio.sv
// MMIO GPIO controller: synchronised inputs, atomic output ops, and sticky
// edge flags with write-1-to-clear that drive a single level interrupt.
module dev_gpio #(
  parameter int NUM_IO      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stb,
  output logic              ack,
  input  logic [9:0]        addr,
  input  logic              rw,
  input  logic [31:0]       dtw,
  output logic [31:0]       dtr,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq
);

  localparam logic [9:0] A_IN    = 10'd0;
  localparam logic [9:0] A_OUT   = 10'd1;
  localparam logic [9:0] A_OEB   = 10'd2;
  localparam logic [9:0] A_IENR  = 10'd3;
  localparam logic [9:0] A_IENF  = 10'd4;
  localparam logic [9:0] A_RFLAG = 10'd5;
  localparam logic [9:0] A_FFLAG = 10'd6;
  localparam logic [9:0] A_SET   = 10'd7;
  localparam logic [9:0] A_CLR   = 10'd8;
  localparam logic [9:0] A_TGL   = 10'd9;

  logic [NUM_IO-1:0] sync_p [SYNC_STAGES];
  logic [NUM_IO-1:0] prev_p;
  logic [NUM_IO-1:0] out_r, oeb_r, ienr_r, ienf_r, rflag_r, fflag_r;
  logic [NUM_IO-1:0] sync_in, rise, fall, wdat, out_nx, clr_rf, clr_ff;
  logic [31:0]       rdat;
  logic              acc, wr;
  logic              unused_dtw;

  function automatic logic [31:0] zext(input logic [NUM_IO-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_IO-1:0] = v;
    return r;
  endfunction

  assign unused_dtw = ^dtw;
  assign wdat       = dtw[NUM_IO-1:0];
  assign acc        = stb & ~ack;
  assign wr         = acc & rw;

  assign sync_in = sync_p[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_p;
  assign fall    = ~sync_in & prev_p;
  assign clr_rf  = (wr && addr == A_RFLAG) ? wdat : '0;
  assign clr_ff  = (wr && addr == A_FFLAG) ? wdat : '0;

  // input synchroniser chain followed by the edge-detect history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync_in;
    end
  end

  always_comb begin
    out_nx = out_r;
    if (wr) begin
      case (addr)
        A_OUT:   out_nx = wdat;
        A_SET:   out_nx = out_r | wdat;
        A_CLR:   out_nx = out_r & ~wdat;
        A_TGL:   out_nx = out_r ^ wdat;
        default: out_nx = out_r;
      endcase
    end
  end

  always_comb begin
    rdat = '0;
    case (addr)
      A_IN:    rdat = zext(sync_in);
      A_OUT:   rdat = zext(out_r);
      A_OEB:   rdat = zext(oeb_r);
      A_IENR:  rdat = zext(ienr_r);
      A_IENF:  rdat = zext(ienf_r);
      A_RFLAG: rdat = zext(rflag_r);
      A_FFLAG: rdat = zext(fflag_r);
      default: rdat = '0;
    endcase
  end

  // register file and bus handshake; new edges take priority over W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack     <= 1'b0;
      dtr     <= '0;
      out_r   <= '0;
      oeb_r   <= '1;
      ienr_r  <= '0;
      ienf_r  <= '0;
      rflag_r <= '0;
      fflag_r <= '0;
    end else begin
      ack <= acc;
      if (acc) dtr <= rdat;
      out_r <= out_nx;
      if (wr && addr == A_OEB)  oeb_r  <= wdat;
      if (wr && addr == A_IENR) ienr_r <= wdat;
      if (wr && addr == A_IENF) ienf_r <= wdat;
      rflag_r <= (rflag_r & ~clr_rf) | (rise & oeb_r & ienr_r);
      fflag_r <= (fflag_r & ~clr_ff) | (fall & oeb_r & ienf_r);
    end
  end

  assign io_out = out_r;
  assign io_oeb = oeb_r;
  assign irq    = (|(rflag_r & ienr_r)) | (|(fflag_r & ienf_r));

endmodule

// File: tb/tb_dev_gpio.sv
// Bench for dev_gpio: a 32-channel instance checked every cycle against a
// register-level model, plus an 8-channel / 3-stage instance with directed checks.
`timescale 1ns/1ps
module tb_dev_gpio;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stb, rw, ack, irq;
  logic [9:0]  addr;
  logic [31:0] dtw, dtr, io_in, io_out, io_oeb;

  logic        b_stb, b_rw, b_ack, b_irq;
  logic [9:0]  b_addr;
  logic [31:0] b_dtw, b_dtr;
  logic [7:0]  b_in, b_out, b_oeb;

  int n_checks = 0;
  int n_fail   = 0;

  dev_gpio #(.NUM_IO(32), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .ack(ack), .addr(addr), .rw(rw),
    .dtw(dtw), .dtr(dtr), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq));

  dev_gpio #(.NUM_IO(8), .SYNC_STAGES(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .stb(b_stb), .ack(b_ack), .addr(b_addr), .rw(b_rw),
    .dtw(b_dtw), .dtr(b_dtr), .io_in(b_in), .io_out(b_out), .io_oeb(b_oeb), .irq(b_irq));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Register-level model: IN is io_in as sampled S edges ago, edges come from
  // comparing the last two such samples.
  logic [31:0] m_out, m_oeb, m_ienr, m_ienf, m_rf, m_ff, m_dtr;
  logic        m_ack;
  logic [31:0] hist [0:S];
  logic [31:0] m_in, m_rise, m_fall, m_rd, m_crf, m_cff;
  logic        m_acc, m_wr;

  assign m_in   = hist[S-1];
  assign m_rise = hist[S-1] & ~hist[S];
  assign m_fall = ~hist[S-1] & hist[S];
  assign m_acc  = stb && !m_ack;
  assign m_wr   = m_acc && rw;
  assign m_crf  = (m_wr && addr == 10'd5) ? dtw : 32'h0;
  assign m_cff  = (m_wr && addr == 10'd6) ? dtw : 32'h0;

  always_comb begin
    m_rd = 32'h0;
    case (addr)
      10'd0: m_rd = m_in;
      10'd1: m_rd = m_out;
      10'd2: m_rd = m_oeb;
      10'd3: m_rd = m_ienr;
      10'd4: m_rd = m_ienf;
      10'd5: m_rd = m_rf;
      10'd6: m_rd = m_ff;
      default: m_rd = 32'h0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 0; m_oeb <= 32'hFFFFFFFF; m_ienr <= 0; m_ienf <= 0;
      m_rf <= 0; m_ff <= 0; m_dtr <= 0; m_ack <= 1'b0;
      for (int i = 0; i <= S; i++) hist[i] <= 0;
    end else begin
      m_ack <= m_acc;
      if (m_acc) m_dtr <= m_rd;
      m_rf <= (m_rf & ~m_crf) | (m_rise & m_oeb & m_ienr);
      m_ff <= (m_ff & ~m_cff) | (m_fall & m_oeb & m_ienf);
      if (m_wr) begin
        case (addr)
          10'd1: m_out  <= dtw;
          10'd2: m_oeb  <= dtw;
          10'd3: m_ienr <= dtw;
          10'd4: m_ienf <= dtw;
          10'd7: m_out  <= m_out | dtw;
          10'd8: m_out  <= m_out & ~dtw;
          10'd9: m_out  <= m_out ^ dtw;
          default: ;
        endcase
      end
      hist[0] <= io_in;
      for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
    end
  end

  always @(negedge clk) begin
    check("m_ack", {31'b0, ack}, {31'b0, m_ack});
    check("m_io_out", io_out, m_out);
    check("m_io_oeb", io_oeb, m_oeb);
    check("m_irq", {31'b0, irq}, {31'b0, (|(m_rf & m_ienr)) | (|(m_ff & m_ienf))});
    if (m_ack) check("m_dtr", dtr, m_dtr);
  end

  // Caller is just after a rising edge; returns data and edges until ack.
  task automatic go(input logic w, input logic [9:0] a, input logic [31:0] d,
                    output logic [31:0] q, output int lat);
    stb = 1'b1; rw = w; addr = a; dtw = d; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack && lat < 8);
    q = dtr;
    stb = 1'b0;
    if (!ack) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: addr %0d got no ack, expected ack", a);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    logic [31:0] q; int lat;
    @(posedge clk); #1; go(1'b1, a, d, q, lat);
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] q);
    int lat;
    @(posedge clk); #1; go(1'b0, a, 32'h0, q, lat);
  endtask

  task automatic go8(input logic w, input logic [9:0] a, input logic [31:0] d,
                     output logic [31:0] q);
    int lat;
    b_stb = 1'b1; b_rw = w; b_addr = a; b_dtw = d; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!b_ack && lat < 8);
    q = b_dtr;
    b_stb = 1'b0;
    check("b_ack_latency", lat, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int lat, acks, n;
    stb = 0; rw = 0; addr = 0; dtw = 0; io_in = 0;
    b_stb = 0; b_rw = 0; b_addr = 0; b_dtw = 0; b_in = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // reset abort in the middle of a write
    wr(2, 32'h0000FF00);
    wr(1, 32'h12345678);
    @(posedge clk); #1;
    stb = 1; rw = 1; addr = 1; dtw = 32'hDEADBEEF;
    #2 rst_n = 1'b0;
    #1;
    check("rst_io_oeb", io_oeb, 32'hFFFFFFFF);
    check("rst_io_out", io_out, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    stb = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_ack", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    go(1'b0, 10'd2, 32'h0, q, lat);
    check("rst_rd_oeb", q, 32'hFFFFFFFF);
    check("rst_rd_lat", lat, 1);

    // atomic output operations
    wr(1, 32'h0000F0F0);
    wr(7, 32'h0000000F); check("set", io_out, 32'h0000F0FF);
    wr(8, 32'h000000F0); check("clr", io_out, 32'h0000F00F);
    wr(9, 32'hFFFF0000); check("tgl", io_out, 32'hFFFFF00F);
    rd(1, q); check("rd_out", q, 32'hFFFFF00F);
    rd(7, q); check("rd_set_zero", q, 32'h0);

    // stb held four cycles
    @(posedge clk); #1;
    stb = 1; rw = 0; addr = 1; acks = 0;
    repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
    stb = 0;
    check("held_acks", acks, 2);

    // rising-edge interrupt latency and acknowledge
    wr(3, 32'h1);
    @(posedge clk); #1; io_in[0] = 1'b1;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (irq && n == 0) n = i;
    end
    check("rise_latency", n, S + 1);
    rd(5, q); check("rflag_set", q, 32'h1);
    wr(5, 32'h1); check("w1c_irq", {31'b0, irq}, 32'h0);
    rd(5, q); check("rflag_clr", q, 32'h0);

    // W1C colliding with a new fall on bit 3
    wr(3, 32'h0); wr(4, 32'h8);
    @(posedge clk); #1; io_in[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1 io_in[3] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    go(1'b1, 10'd6, 32'h8, q, lat);
    rd(6, q); check("collision_fflag", q, 32'h8);
    check("collision_irq", {31'b0, irq}, 32'h1);
    wr(4, 32'h0);
    check("mask_irq", {31'b0, irq}, 32'h0);
    rd(6, q); check("mask_fflag", q, 32'h8);
    wr(6, 32'h8);
    rd(6, q); check("fflag_clr", q, 32'h0);

    // fall on an output channel is ignored
    wr(2, ~32'h20); wr(4, 32'h20);
    @(posedge clk); #1; io_in[5] = 1'b1;
    repeat (5) @(posedge clk);
    #1 io_in[5] = 1'b0;
    repeat (6) @(posedge clk);
    rd(6, q); check("oeb0_no_flag", q, 32'h0);
    check("oeb0_irq", {31'b0, irq}, 32'h0);
    wr(2, 32'hFFFFFFFF); wr(4, 32'h0);

    // 8-channel, 3-stage instance
    check("b_rst_oeb", {24'b0, b_oeb}, 32'hFF);
    @(posedge clk); #1; go8(1'b1, 10'd1, 32'hFFFFFFFF, q);
    check("b_io_out", {24'b0, b_out}, 32'hFF);
    @(posedge clk); #1; go8(1'b0, 10'd1, 32'h0, q);
    check("b_rd_out", q, 32'h000000FF);
    @(posedge clk); #1; go8(1'b0, 10'd12, 32'h0, q);
    check("b_unmapped", q, 32'h0);
    @(posedge clk); #1; b_in = 8'hA5;
    @(posedge clk); @(posedge clk); #1;
    go8(1'b0, 10'd0, 32'h0, q);
    check("b_in_early", q, 32'h0);
    @(posedge clk); #1; b_in = 8'h3C;
    repeat (3) @(posedge clk);
    #1 go8(1'b0, 10'd0, 32'h0, q);
    check("b_in_3cyc", q, 32'h3C);
    check("b_irq", {31'b0, b_irq}, 32'h0);

    // randomized traffic against the model
    repeat (3000) begin
      @(posedge clk); #1;
      stb  = ($urandom_range(0, 2) != 0);
      rw   = 1'($urandom_range(0, 1));
      addr = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr[8] = 1'b1;
      dtw  = $urandom;
      if ($urandom_range(0, 1) == 0) io_in = io_in ^ ($urandom & $urandom & $urandom);
    end
    stb = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dev_gpio.md
# dev_gpio

Parametrised MMIO GPIO controller for the HS32 SoC, attached to one device slot of `dev_intercon`. It generalises the fixed 32-bit GPIO logic in the core top level. It adds:
- a configurable channel count and synchroniser depth;
- atomic set/clear/toggle of outputs;
- sticky rising/falling-edge interrupt flags with write-1-to-clear acknowledge;
- a single level interrupt output for `hs32_aic`.

## Interface
Parameters
- `NUM_IO`, 32: number of GPIO channels, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

Ports
- `clk` in 1: system clock; one clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `stb` in 1: access strobe from `dev_intercon`; held until `ack`.
- `ack` out 1: registered one-cycle acknowledge.
- `addr` in 10: word register index.
- `rw` in 1: 1 = write, 0 = read.
- `dtw` in 32: write data.
- `dtr` out 32: registered read data; valid while `ack`=1.
- `io_in` in NUM_IO: raw pad inputs (asynchronous).
- `io_out` out NUM_IO: output data register.
- `io_oeb` out NUM_IO: output enable, active low (1 = input).
- `irq` out 1: level interrupt, = |(RFLAG & IENR) | |(FFLAG & IENF).

## Operation
- Register map (`addr`):
  - 0 IN (RO): synchronised inputs.
  - 1 OUT (RW).
  - 2 OEB (RW).
  - 3 IENR (RW): rising-edge interrupt enable.
  - 4 IENF (RW): falling-edge interrupt enable.
  - 5 RFLAG (R/W1C).
  - 6 FFLAG (R/W1C).
  - 7 SET (WO): OUT |= dtw.
  - 8 CLR (WO): OUT &= ~dtw.
  - 9 TGL (WO): OUT ^= dtw.
  - Other addresses, and reads of 7..9, return 0. Writes to 0 and to unmapped addresses are ignored but still acked.
- Widths:
  - `dtw[NUM_IO-1:0]` is used; upper bits are ignored.
  - Reads are zero-extended to 32 bits.
- Input path:
  - `io_in` passes through a chain of SYNC_STAGES flops, then one `prev` flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edges are qualified by OEB bit = 1 (channel is an input).
- Flags:
  - RFLAG[i] sets on a qualified rise when IENR[i]=1. FFLAG[i] sets on a qualified fall when IENF[i]=1.
  - Flags hold until cleared by writing 1.
  - Clearing IENx does not clear the flag, but it masks the flag from `irq`.
- Bus state: 1-bit `ack` register.
  - IDLE (ack=0): if `stb`=1, the access executes on this edge, ack goes to 1, and `dtr` is loaded.
  - ACK (ack=1): always returns to IDLE. An access never executes while ack=1.
  - If `stb` is held continuously, one access completes every 2 cycles.
- Simultaneous events:
  - W1C and a new qualified edge on the same bit in the same cycle: the set wins, and the flag stays 1.
  - SET/CLR/TGL modify OUT using the OUT value before the edge.
- Reset values:
  - ack=0, dtr=0, OUT=0, io_out=0, OEB=all 1s, io_oeb=all 1s, IENR=0, IENF=0, RFLAG=0, FFLAG=0, irq=0.
  - Sync and `prev` flops reset to 0.
- Reset mid-access: everything returns to reset values immediately, and no ack is issued for the aborted access.

## Timing
- Write: `stb`,`rw`=1 sampled at edge k. The register updates at edge k and `ack`=1 in cycle k+1. `io_out`/`io_oeb` change in cycle k+1.
- Read: `dtr` is captured at edge k from register state before edge k, and is valid with `ack` in cycle k+1. The master must drop or re-present `stb` after `ack`.
- Input latency: an `io_in` edge stable before edge j appears in IN after SYNC_STAGES edges. The flag and `irq` assert one edge later, at edge j+SYNC_STAGES.
- The spurious rise after reset release (input already high) is harmless because IENR=0 then.
- Edges are detected once per transition. Pulses shorter than one clock may be lost. This is required behaviour, not a bug.

## Test plan
- **Reset:** assert rst_n=0 mid-write with NUM_IO=32 → io_oeb=FFFFFFFF, io_out=0, ack=0, irq=0. After release, a read of addr 2 returns FFFFFFFF with ack exactly 1 cycle after stb.
- **Atomic ops:**
  - write OUT=0000F0F0, then SET 0000000F → io_out=0000F0FF;
  - then CLR 000000F0 → 0000F00F;
  - then TGL FFFF0000 → FFFFF00F.
  - Each access is acked once, and `stb` held for 4 cycles yields 2 acks.
- **Rising interrupt:** OEB=all 1s, IENR=1, io_in[0] 0→1 → RFLAG=1 and irq=1 after exactly SYNC_STAGES+1 edges. Write RFLAG=1 → irq=0 in the next cycle.
- **Collision and masking:**
  - W1C on FFLAG[3] in the same cycle as a qualified fall on bit 3 → FFLAG[3] stays 1.
  - A fall on a bit with OEB=0 never sets a flag.
  - IENF cleared with FFLAG set → irq=0, and FFLAG still reads 1.
- **Parametrisation:** NUM_IO=8, SYNC_STAGES=3.
  - Write FFFFFFFF to OUT → reads back 000000FF.
  - IN reflects io_in after 3 cycles.
  - Unmapped addr 12 reads 0 and is acked.
